// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD display path: FSM encodings, DC levels and
// the controller command bytes used by the init/show generators.
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_SETUP = 4'b0010,
        ST_HIGH  = 4'b0100,
        ST_LOW   = 4'b1000
    } lcd_state_e;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    function automatic logic [7:0] shift_msb_out(input logic [7:0] sr);
        return {sr[6:0], 1'b0};
    endfunction

endpackage

// File: rtl/lcd_spi_tick.sv
// SCLK half-period timer: strobes half_done_o on the last cycle of every
// SCLK_HALF-cycle phase while run_i is high; restart_i zeroes the phase.
module lcd_spi_tick #(
    parameter int unsigned SCLK_HALF = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    input  logic run_i,
    output logic half_done_o
);

    localparam logic [7:0] HALF_LAST = 8'(SCLK_HALF - 1);

    logic [7:0] phase_q;
    logic [7:0] phase_d;

    assign half_done_o = run_i && (phase_q == HALF_LAST);

    // next phase count
    always_comb begin
        phase_d = phase_q;
        if (restart_i) begin
            phase_d = 8'd0;
        end else if (!run_i) begin
            phase_d = 8'd0;
        end else if (phase_q == HALF_LAST) begin
            phase_d = 8'd0;
        end else begin
            phase_d = phase_q + 8'd1;
        end
    end

    // phase register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= 8'd0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/lcd_spi_write.sv
// Serializes one {dc, byte} word onto a 4-wire mode-0 SPI LCD bus, MSB first,
// and pulses wr_done when the last bit has been clocked out.
module lcd_spi_write
    import lcd_pkg::*;
#(
    parameter int unsigned SCLK_HALF = 2,
    parameter int unsigned GAP       = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       en_write,
    input  logic [8:0] data_in,
    output logic       busy,
    output logic       wr_done,
    output logic       lcd_cs,
    output logic       lcd_dc,
    output logic       lcd_sclk,
    output logic       lcd_mosi
);

    localparam logic [3:0] GAP_INIT = 4'(GAP);

    lcd_state_e state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic [3:0] gap_q, gap_d;
    logic       cs_q, cs_d;
    logic       dc_q, dc_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       accept_s;
    logic       half_done_s;

    lcd_spi_tick #(.SCLK_HALF(SCLK_HALF)) u_tick (
        .clk_i      (sys_clk),
        .rst_i      (sys_rst),
        .restart_i  (accept_s),
        .run_i      (state_q != ST_IDLE),
        .half_done_o(half_done_s)
    );

    // FSM next state, shifter and bus outputs
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        cs_d     = cs_q;
        dc_d     = dc_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        accept_s = 1'b0;

        // post-word CS-high gap; busy drops as the count reaches zero
        if (gap_q != 4'd0) begin
            gap_d = gap_q - 4'd1;
            if (gap_q == 4'd1) begin
                busy_d = 1'b0;
            end else begin
                busy_d = busy_q;
            end
        end else begin
            gap_d = gap_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (en_write && (gap_q == 4'd0)) begin
                    accept_s = 1'b1;
                    shift_d  = data_in[7:0];
                    dc_d     = data_in[8];
                    mosi_d   = data_in[7];
                    cs_d     = 1'b0;
                    busy_d   = 1'b1;
                    bit_d    = 3'd0;
                    state_d  = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (half_done_s) begin
                    sclk_d  = 1'b1;
                    state_d = ST_HIGH;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_HIGH: begin
                if (half_done_s) begin
                    sclk_d  = 1'b0;
                    shift_d = shift_msb_out(shift_q);
                    mosi_d  = shift_q[6];
                    state_d = ST_LOW;
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (half_done_s) begin
                    if (bit_q == 3'd7) begin
                        cs_d    = 1'b1;
                        done_d  = 1'b1;
                        gap_d   = GAP_INIT;
                        state_d = ST_IDLE;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        sclk_d  = 1'b1;
                        state_d = ST_HIGH;
                    end
                end else begin
                    state_d = ST_LOW;
                end
            end
            default: begin
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            shift_q <= 8'd0;
            bit_q   <= 3'd0;
            gap_q   <= 4'd0;
            cs_q    <= 1'b1;
            dc_q    <= DC_CMD;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            cs_q    <= cs_d;
            dc_q    <= dc_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign wr_done  = done_q;
    assign lcd_cs   = cs_q;
    assign lcd_dc   = dc_q;
    assign lcd_sclk = sclk_q;
    assign lcd_mosi = mosi_q;

endmodule

// File: tb/tb_lcd_spi_write.sv
// Directed bench for lcd_spi_write: default instance plus a SCLK_HALF=1 instance.
module tb_lcd_spi_write;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en0, en1;
    logic [8:0] d0, d1;
    logic       busy0, done0, cs0, dc0, sclk0, mosi0;
    logic       busy1, done1, cs1, dc1, sclk1, mosi1;

    lcd_spi_write dut (
        .sys_clk(clk), .sys_rst(rst), .en_write(en0), .data_in(d0),
        .busy(busy0), .wr_done(done0), .lcd_cs(cs0), .lcd_dc(dc0),
        .lcd_sclk(sclk0), .lcd_mosi(mosi0)
    );

    lcd_spi_write #(.SCLK_HALF(1), .GAP(3)) dut1 (
        .sys_clk(clk), .sys_rst(rst), .en_write(en1), .data_in(d1),
        .busy(busy1), .wr_done(done1), .lcd_cs(cs1), .lcd_dc(dc1),
        .lcd_sclk(sclk1), .lcd_mosi(mosi1)
    );

    int  checks = 0;
    int  errors = 0;
    time t_done0 = 0;

    typedef struct {
        logic [8:0] d;
        bit         sel;
        logic [7:0] eb;
        int         elat;
        bit         chk_sep;
    } vec_t;

    vec_t vt[5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one word starting at a negedge; monitor until wr_done, then 3 more cycles.
    task automatic send(input logic [8:0] d, input bit sel, input int hold,
                        output logic [7:0] b, output int lat, output int rises,
                        output int dcbad, output int cs_done, output int sep,
                        output int bfall);
        logic prev, sc, ms, cs, dn, dcv, bz;
        b = 8'd0; lat = -1; rises = 0; dcbad = 0; cs_done = 0; sep = -1; bfall = -1;
        prev = 1'b0;
        if (sel) begin en1 = 1'b1; d1 = d; end
        else     begin en0 = 1'b1; d0 = d; end
        @(posedge clk);
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                if (sel) begin d1 = ~d; if (hold < 0) en1 = 1'b0; end
                else     begin d0 = ~d; if (hold < 0) en0 = 1'b0; end
                if (!sel) sep = int'(($time - t_done0) / 10);
            end
            sc  = sel ? sclk1 : sclk0;
            ms  = sel ? mosi1 : mosi0;
            cs  = sel ? cs1   : cs0;
            dn  = sel ? done1 : done0;
            dcv = sel ? dc1   : dc0;
            if (sc && !prev) begin
                rises++;
                b = {b[6:0], ms};
            end
            prev = sc;
            if (!cs && (dcv != d[8])) dcbad++;
            if (dn) begin
                lat = cyc;
                cs_done = int'(cs);
                break;
            end
        end
        if (!sel) t_done0 = $time;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == hold) begin
                if (sel) en1 = 1'b0; else en0 = 1'b0;
            end
            bz = sel ? busy1 : busy0;
            if (!bz && bfall < 0) bfall = k;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad0, bad1, rises, got, cyc;
        logic prev;
        logic [7:0] b;
        int lat, r, dcbad, csd, sep, bfall;

        vt[0] = '{d: 9'h02C, sel: 1'b0, eb: 8'h2C, elat: 34, chk_sep: 1'b0};
        vt[1] = '{d: 9'h0AA, sel: 1'b0, eb: 8'hAA, elat: 34, chk_sep: 1'b0};
        vt[2] = '{d: 9'h1F8, sel: 1'b0, eb: 8'hF8, elat: 34, chk_sep: 1'b0};
        vt[3] = '{d: 9'h100, sel: 1'b0, eb: 8'h00, elat: 34, chk_sep: 1'b1};
        vt[4] = '{d: 9'h181, sel: 1'b1, eb: 8'h81, elat: 17, chk_sep: 1'b0};

        rst = 1'b1; en0 = 1'b0; en1 = 1'b0; d0 = 9'd0; d1 = 9'd0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // idle after reset
        bad0 = 0; bad1 = 0;
        repeat (50) begin
            @(negedge clk);
            if (cs0 !== 1'b1 || sclk0 !== 1'b0 || mosi0 !== 1'b0 || done0 !== 1'b0 ||
                busy0 !== 1'b0 || dc0 !== 1'b0) bad0++;
            if (cs1 !== 1'b1 || sclk1 !== 1'b0 || mosi1 !== 1'b0 || done1 !== 1'b0 ||
                busy1 !== 1'b0 || dc1 !== 1'b0) bad1++;
        end
        check("reset_idle", bad0, 0);
        check("reset_idle_h1", bad1, 0);

        // reset after the 4th SCLK rise of 9'h0FF
        en0 = 1'b1; d0 = 9'h0FF;
        @(posedge clk);
        @(negedge clk);
        en0 = 1'b0;
        rises = 0; prev = 1'b0;
        for (cyc = 0; cyc < 100; cyc++) begin
            if (sclk0 && !prev) rises++;
            prev = sclk0;
            if (rises == 4) break;
            @(negedge clk);
        end
        check("midrst_rises", rises, 4);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cs", int'(cs0), 1);
        check("midrst_sclk", int'(sclk0), 0);
        check("midrst_done", int'(done0), 0);
        rst = 1'b0;
        got = 0;
        repeat (40) begin
            @(negedge clk);
            if (done0 || !cs0) got++;
        end
        check("midrst_quiet", got, 0);

        // table of single-pulse words
        for (int i = 0; i < 5; i++) begin
            send(vt[i].d, vt[i].sel, -1, b, lat, r, dcbad, csd, sep, bfall);
            check($sformatf("v%0d_byte", i), int'(b), int'(vt[i].eb));
            check($sformatf("v%0d_rises", i), r, 8);
            check($sformatf("v%0d_latency", i), lat, vt[i].elat);
            check($sformatf("v%0d_dc", i), dcbad, 0);
            check($sformatf("v%0d_cs_at_done", i), csd, 1);
            if (vt[i].chk_sep) check($sformatf("v%0d_cs_gap", i), sep, 4);
        end

        // level request held 2 cycles past wr_done
        send(9'h155, 1'b0, 2, b, lat, r, dcbad, csd, sep, bfall);
        check("level_byte", int'(b), 8'h55);
        check("level_dc", dcbad, 0);
        check("level_latency", lat, 34);
        check("level_busy_fall", bfall, 3);
        got = 0;
        repeat (20) begin
            @(negedge clk);
            if (!cs0 || done0 || busy0) got++;
        end
        check("level_no_requeue", got, 0);
        check("level_dc_hold", int'(dc0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
